// File: rtl/eth_tx_framer.sv
// Transmit Ethernet framer: pulls ARP/IP payloads from send_buffer, prepends the
// 14-byte header, zero-pads to a minimum payload and streams 32-bit words.
module eth_tx_framer #(
  parameter logic [47:0] MY_MAC        = 48'h01606e11020f,
  parameter logic [15:0] ETYPE_IP      = 16'h0800,
  parameter logic [15:0] ETYPE_ARP     = 16'h0806,
  parameter int unsigned ARP_WORDS     = 7,
  parameter int unsigned MIN_PAY_WORDS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ip_ready,
  input  logic [47:0] cpu_ip_mac,
  input  logic [31:0] cpu_ip_data,
  input  logic [7:0]  cpu_ip_length,
  output logic [7:0]  cpu_ip_index,
  output logic        cpu_ip_done,
  input  logic        cpu_arp_ready,
  input  logic [47:0] cpu_arp_mac,
  input  logic [31:0] cpu_arp_data,
  output logic [2:0]  cpu_arp_index,
  output logic        cpu_arp_done,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_sof,
  output logic        tx_eof
);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, H3, PAY, TAIL, DONE} state_t;

  localparam logic [7:0] ARP_N = 8'(ARP_WORDS);
  localparam logic [7:0] MIN_M = 8'(MIN_PAY_WORDS);
  localparam logic [7:0] ARP_M = (ARP_N > MIN_M) ? ARP_N : MIN_M;

  state_t      r_state;
  logic        r_isArp;
  logic [47:0] r_dst;
  logic [7:0]  r_n;
  logic [7:0]  r_m;
  logic [8:0]  r_cnt;
  logic [7:0]  r_index;
  logic [15:0] r_carry;
  logic        r_valid;
  logic        r_sof;
  logic        r_eof;
  logic        r_ipDone;
  logic        r_arpDone;

  logic        w_xfer;
  logic [31:0] w_word;
  logic [31:0] w_pi;
  logic [8:0]  w_cntNext;
  logic [7:0]  w_nextIdx;
  logic [31:0] w_data;

  assign w_xfer    = r_valid & tx_ready;
  assign w_word    = r_isArp ? cpu_arp_data : cpu_ip_data;
  // Words past the real payload length are padding, whatever the buffer returns.
  assign w_pi      = (r_cnt < {1'b0, r_n}) ? w_word : 32'h0;
  assign w_cntNext = r_cnt + 9'd1;
  assign w_nextIdx = (w_cntNext < {1'b0, r_n}) ? w_cntNext[7:0] : (r_n - 8'd1);

  always_comb begin
    w_data = 32'h0;
    case (r_state)
      H0:      w_data = r_dst[47:16];
      H1:      w_data = {r_dst[15:0], MY_MAC[47:32]};
      H2:      w_data = MY_MAC[31:0];
      H3:      w_data = {(r_isArp ? ETYPE_ARP : ETYPE_IP), w_pi[31:16]};
      PAY:     w_data = {r_carry, w_pi[31:16]};
      TAIL:    w_data = {r_carry, 16'h0};
      default: w_data = 32'h0;
    endcase
  end

  assign tx_data       = w_data;
  assign tx_valid      = r_valid;
  assign tx_sof        = r_sof;
  assign tx_eof        = r_eof;
  assign cpu_ip_done   = r_ipDone;
  assign cpu_arp_done  = r_arpDone;
  assign cpu_ip_index  = r_isArp ? 8'h0 : r_index;
  assign cpu_arp_index = r_isArp ? r_index[2:0] : 3'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_isArp   <= 1'b0;
      r_dst     <= 48'h0;
      r_n       <= 8'h0;
      r_m       <= 8'h0;
      r_cnt     <= 9'h0;
      r_index   <= 8'h0;
      r_carry   <= 16'h0;
      r_valid   <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_ipDone  <= 1'b0;
      r_arpDone <= 1'b0;
    end else begin
      r_ipDone  <= 1'b0;
      r_arpDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_arp_ready) begin
            r_isArp <= 1'b1;
            r_dst   <= cpu_arp_mac;
            r_n     <= ARP_N;
            r_m     <= ARP_M;
            r_cnt   <= 9'h0;
            r_index <= 8'h0;
            r_valid <= 1'b1;
            r_sof   <= 1'b1;
            r_state <= H0;
          end else if (cpu_ip_ready) begin
            r_isArp <= 1'b0;
            if (cpu_ip_length != 8'h0) begin
              r_dst   <= cpu_ip_mac;
              r_n     <= cpu_ip_length;
              r_m     <= (cpu_ip_length > MIN_M) ? cpu_ip_length : MIN_M;
              r_cnt   <= 9'h0;
              r_index <= 8'h0;
              r_valid <= 1'b1;
              r_sof   <= 1'b1;
              r_state <= H0;
            end else begin
              r_ipDone <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        H0: if (w_xfer) begin
          r_sof   <= 1'b0;
          r_state <= H1;
        end
        H1: if (w_xfer) r_state <= H2;
        H2: if (w_xfer) r_state <= H3;
        // H3 carries payload word 0; PAY carries words 1..M-1 shifted by 16 bits.
        H3, PAY: if (w_xfer) begin
          r_carry <= w_pi[15:0];
          if (r_cnt == ({1'b0, r_m} - 9'd1)) begin
            r_eof   <= 1'b1;
            r_state <= TAIL;
          end else begin
            r_cnt   <= w_cntNext;
            r_index <= w_nextIdx;
            r_state <= PAY;
          end
        end
        TAIL: if (w_xfer) begin
          r_valid <= 1'b0;
          r_eof   <= 1'b0;
          if (r_isArp) r_arpDone <= 1'b1;
          else         r_ipDone  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_cnt   <= 9'h0;
          r_index <= 8'h0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a small send_buffer model feeds payloads
// while transferred words are captured and compared against hand-computed tables.
module tb_eth_tx_framer;

  typedef struct {
    int          scen;
    string       name;
    int          word;
    logic [31:0] data;
    bit          sof;
    bit          eof;
    int          idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ip_ready;
  logic [47:0] cpu_ip_mac;
  logic [31:0] cpu_ip_data;
  logic [7:0]  cpu_ip_length;
  logic [7:0]  cpu_ip_index;
  logic        cpu_ip_done;
  logic        cpu_arp_ready;
  logic [47:0] cpu_arp_mac;
  logic [31:0] cpu_arp_data;
  logic [2:0]  cpu_arp_index;
  logic        cpu_arp_done;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sof;
  logic        tx_eof;

  logic [31:0] ipMem [256];
  logic [31:0] arpMem [8];

  logic [31:0] capData [$];
  bit          capSof [$];
  bit          capEof [$];
  int          capIdx [$];
  vec_t        vecs [$];

  int          passCount;
  int          checkCount;
  int          ipDones;
  int          arpDones;
  int          doneSeq;
  int          validCycles;
  int          stallCount;
  bit          readyMode;
  logic [7:0]  lfsr;
  bit          prevStall;
  logic [31:0] prevData;
  logic [7:0]  prevIdx;

  always #5 clk = ~clk;

  assign cpu_ip_data  = ipMem[cpu_ip_index];
  assign cpu_arp_data = arpMem[cpu_arp_index];

  eth_tx_framer dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_ip_ready  (cpu_ip_ready),
    .cpu_ip_mac    (cpu_ip_mac),
    .cpu_ip_data   (cpu_ip_data),
    .cpu_ip_length (cpu_ip_length),
    .cpu_ip_index  (cpu_ip_index),
    .cpu_ip_done   (cpu_ip_done),
    .cpu_arp_ready (cpu_arp_ready),
    .cpu_arp_mac   (cpu_arp_mac),
    .cpu_arp_data  (cpu_arp_data),
    .cpu_arp_index (cpu_arp_index),
    .cpu_arp_done  (cpu_arp_done),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_sof        (tx_sof),
    .tx_eof        (tx_eof)
  );

  function automatic vec_t mkVec(input int scen, input string name, input int word,
                                 input logic [31:0] data, input bit sof, input bit eof,
                                 input int idx);
    vec_t v;
    v.scen = scen;
    v.name = name;
    v.word = word;
    v.data = data;
    v.sof  = sof;
    v.eof  = eof;
    v.idx  = idx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic clearCapture();
    capData.delete();
    capSof.delete();
    capEof.delete();
    capIdx.delete();
    ipDones     = 0;
    arpDones    = 0;
    doneSeq     = 0;
    validCycles = 0;
    stallCount  = 0;
    prevStall   = 1'b0;
  endtask

  // One clock of the send_buffer/MAC model, evaluated on the falling edge.
  task automatic stepCycle();
    @(negedge clk);
    if (readyMode) begin
      lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      tx_ready = lfsr[0];
    end else begin
      tx_ready = 1'b1;
    end
    if (prevStall) begin
      checkOutput("stall_data", tx_data, prevData);
      checkOutput("stall_index", cpu_ip_index, prevIdx);
    end
    if (tx_valid) validCycles++;
    if (tx_valid && tx_ready) begin
      capData.push_back(tx_data);
      capSof.push_back(tx_sof);
      capEof.push_back(tx_eof);
      capIdx.push_back(int'(cpu_ip_index));
    end
    if (tx_valid && !tx_ready) stallCount++;
    prevStall = tx_valid && !tx_ready;
    prevData  = tx_data;
    prevIdx   = cpu_ip_index;
    if (cpu_ip_done) begin
      ipDones++;
      doneSeq = doneSeq * 10 + 2;
      cpu_ip_ready = 1'b0;
    end
    if (cpu_arp_done) begin
      arpDones++;
      doneSeq = doneSeq * 10 + 1;
      cpu_arp_ready = 1'b0;
    end
  endtask

  task automatic runFrames(input int budget, input int tailCycles);
    int cyc;
    int quiet;
    cyc   = 0;
    quiet = 0;
    while (quiet < tailCycles && cyc < budget) begin
      stepCycle();
      cyc++;
      if (!cpu_ip_ready && !cpu_arp_ready && !tx_valid) quiet++;
      else quiet = 0;
    end
    if (cyc >= budget) begin
      checkCount++;
      $display("[TB] FAIL timeout: frames still active after %0d cycles", budget);
    end
  endtask

  task automatic loadIp(input int n);
    for (int i = 0; i < 256; i++) ipMem[i] = (i < n) ? (32'h1000_0000 + 32'(i)) : 32'hDEAD_BEEF;
    cpu_ip_mac    = 48'h0a0b0c0d0e0f;
    cpu_ip_length = 8'(n);
  endtask

  task automatic applyStimulus(input int scen);
    clearCapture();
    for (int i = 0; i < 8; i++) arpMem[i] = {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
    cpu_arp_mac = 48'hffffffffffff;
    readyMode   = 1'b0;
    case (scen)
      1: cpu_arp_ready = 1'b1;
      2: begin loadIp(20); cpu_ip_ready = 1'b1; end
      3: begin loadIp(20); cpu_ip_ready = 1'b1; cpu_arp_ready = 1'b1; end
      4: begin
        loadIp(3);
        for (int i = 0; i < 3; i++) ipMem[i] = {16'hC000 + 16'(i), 16'hD000 + 16'(i)};
        readyMode    = 1'b1;
        cpu_ip_ready = 1'b1;
      end
      5: begin loadIp(0); cpu_ip_ready = 1'b1; end
      default: begin loadIp(20); cpu_ip_ready = 1'b1; end
    endcase
  endtask

  task automatic checkVectors(input int scen);
    foreach (vecs[k]) begin
      if (vecs[k].scen == scen) begin
        if (vecs[k].word >= capData.size()) begin
          checkOutput({vecs[k].name, "_present"}, capData.size(), vecs[k].word + 1);
        end else begin
          checkOutput({vecs[k].name, "_data"}, capData[vecs[k].word], vecs[k].data);
          checkOutput({vecs[k].name, "_sof"}, capSof[vecs[k].word], vecs[k].sof);
          checkOutput({vecs[k].name, "_eof"}, capEof[vecs[k].word], vecs[k].eof);
          if (vecs[k].idx >= 0) checkOutput({vecs[k].name, "_idx"}, capIdx[vecs[k].word], vecs[k].idx);
        end
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, tx_valid, 0);
    checkOutput({tag, "_data"}, tx_data, 0);
    checkOutput({tag, "_sof"}, tx_sof, 0);
    checkOutput({tag, "_eof"}, tx_eof, 0);
    checkOutput({tag, "_ipidx"}, cpu_ip_index, 0);
    checkOutput({tag, "_arpidx"}, cpu_arp_index, 0);
    checkOutput({tag, "_dones"}, {cpu_ip_done, cpu_arp_done}, 0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    lfsr       = 8'hA5;
    readyMode  = 1'b0;
    tx_ready   = 1'b0;
    cpu_ip_ready  = 1'b0;
    cpu_arp_ready = 1'b0;
    cpu_ip_mac    = 48'h0;
    cpu_arp_mac   = 48'h0;
    cpu_ip_length = 8'h0;
    for (int i = 0; i < 256; i++) ipMem[i] = 32'h0;
    for (int i = 0; i < 8; i++) arpMem[i] = 32'h0;
    clearCapture();

    vecs.push_back(mkVec(1, "arpW0",  0, 32'hffffffff, 1, 0, -1));
    vecs.push_back(mkVec(1, "arpW1",  1, 32'hffff0160, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW2",  2, 32'h6e11020f, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW3",  3, 32'h0806a000, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW4",  4, 32'hb000a001, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW9",  9, 32'hb005a006, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW10", 10, 32'hb0060000, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW11", 11, 32'h00000000, 0, 0, -1));
    vecs.push_back(mkVec(1, "arpW15", 15, 32'h00000000, 0, 1, -1));
    vecs.push_back(mkVec(2, "ipW0",   0, 32'h0a0b0c0d, 1, 0, -1));
    vecs.push_back(mkVec(2, "ipW1",   1, 32'h0e0f0160, 0, 0, -1));
    vecs.push_back(mkVec(2, "ipW2",   2, 32'h6e11020f, 0, 0, -1));
    vecs.push_back(mkVec(2, "ipW3",   3, 32'h08001000, 0, 0, 0));
    vecs.push_back(mkVec(2, "ipW4",   4, 32'h00001000, 0, 0, 1));
    vecs.push_back(mkVec(2, "ipW5",   5, 32'h00011000, 0, 0, 2));
    vecs.push_back(mkVec(2, "ipW13",  13, 32'h00091000, 0, 0, 10));
    vecs.push_back(mkVec(2, "ipW22",  22, 32'h00121000, 0, 0, 19));
    vecs.push_back(mkVec(2, "ipW23",  23, 32'h00130000, 0, 1, 19));
    vecs.push_back(mkVec(3, "bothW0",  0, 32'hffffffff, 1, 0, -1));
    vecs.push_back(mkVec(3, "bothW15", 15, 32'h00000000, 0, 1, -1));
    vecs.push_back(mkVec(3, "bothW16", 16, 32'h0a0b0c0d, 1, 0, -1));
    vecs.push_back(mkVec(3, "bothW19", 19, 32'h08001000, 0, 0, 0));
    vecs.push_back(mkVec(3, "bothW39", 39, 32'h00130000, 0, 1, 19));
    vecs.push_back(mkVec(4, "stW3",  3, 32'h0800c000, 0, 0, 0));
    vecs.push_back(mkVec(4, "stW4",  4, 32'hd000c001, 0, 0, 1));
    vecs.push_back(mkVec(4, "stW5",  5, 32'hd001c002, 0, 0, 2));
    vecs.push_back(mkVec(4, "stW6",  6, 32'hd0020000, 0, 0, 2));
    vecs.push_back(mkVec(4, "stW7",  7, 32'h00000000, 0, 0, 2));
    vecs.push_back(mkVec(4, "stW14", 14, 32'h00000000, 0, 0, 2));
    vecs.push_back(mkVec(4, "stW15", 15, 32'h00000000, 0, 1, 2));

    reset = 1'b1;
    #2 reset = 1'b0;
    #1 checkIdleOutputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    applyStimulus(1);
    runFrames(400, 4);
    checkVectors(1);
    checkOutput("t1_words", capData.size(), 16);
    checkOutput("t1_arp_dones", arpDones, 1);
    checkOutput("t1_ip_dones", ipDones, 0);

    applyStimulus(2);
    runFrames(400, 4);
    checkVectors(2);
    checkOutput("t2_words", capData.size(), 24);
    checkOutput("t2_ip_dones", ipDones, 1);

    applyStimulus(3);
    runFrames(800, 4);
    checkVectors(3);
    checkOutput("t3_words", capData.size(), 40);
    checkOutput("t3_arp_dones", arpDones, 1);
    checkOutput("t3_ip_dones", ipDones, 1);
    checkOutput("t3_done_order", doneSeq, 12);

    applyStimulus(4);
    runFrames(800, 4);
    checkVectors(4);
    checkOutput("t4_words", capData.size(), 16);
    checkOutput("t4_ip_dones", ipDones, 1);
    checkOutput("t4_stalls_seen", stallCount > 0, 1);

    applyStimulus(5);
    runFrames(100, 4);
    checkOutput("t5_words", capData.size(), 0);
    checkOutput("t5_valid_cycles", validCycles, 0);
    checkOutput("t5_ip_dones", ipDones, 1);

    // Reset lands in the middle of an IP frame; the still-queued payload must restart.
    applyStimulus(6);
    begin
      int cyc;
      cyc = 0;
      while (capData.size() < 7 && cyc < 200) begin
        stepCycle();
        cyc++;
      end
      if (cyc >= 200) begin
        checkCount++;
        $display("[TB] FAIL t6_reach_word7: only %0d words before timeout", capData.size());
      end
    end
    reset = 1'b0;
    #1 checkIdleOutputs("t6_inreset");
    repeat (3) stepCycle();
    checkOutput("t6_valid_in_reset", tx_valid, 0);
    checkOutput("t6_no_done", ipDones, 0);
    reset = 1'b1;
    clearCapture();
    runFrames(400, 4);
    checkOutput("t6_words", capData.size(), 24);
    if (capData.size() == 24) begin
      checkOutput("t6_W0_data", capData[0], 32'h0a0b0c0d);
      checkOutput("t6_W0_sof", capSof[0], 1);
      checkOutput("t6_W23_data", capData[23], 32'h00130000);
      checkOutput("t6_W23_eof", capEof[23], 1);
    end
    checkOutput("t6_ip_dones", ipDones, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
